// File: rtl/ofdm_symbol_buffer_if.sv
// rtl/ofdm_symbol_buffer_if.sv - Avalon-ST style stream bundle used on both sides of the symbol buffer
interface ofdm_symbol_buffer_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         startofpacket;
  logic         endofpacket;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/ofdm_symbol_buffer.sv
// rtl/ofdm_symbol_buffer.sv - ping-pong OFDM symbol buffer; define BIT_REVERSE_EN for bit-reversed readout
module ofdm_symbol_buffer #(
  parameter int SYMBOL_LEN = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32
) (
  input  logic                 clock_clk,
  input  logic                 reset_reset,
  ofdm_symbol_buffer_if.slave  asi_in0,
  ofdm_symbol_buffer_if.master aso_out0,
  output logic [15:0]          drop_count
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SYMBOL_LEN - 1);

  // Bank b occupies addresses {b, idx}; the two banks never alias.
  logic [DATA_W-1:0] mem [0:2*SYMBOL_LEN-1];
  logic [DATA_W-1:0] ram_q;

  wstate_t           wstate;
  rstate_t           rstate;
  logic [1:0]        full;
  logic              wbank, rbank;
  logic [ADDR_W-1:0] wcnt, rcnt;
  logic              out_valid, out_sop, out_eop;

  logic              in_xfer;
  logic [DATA_W-1:0] sample;
  logic              in_sop, in_eop;
  logic              we, start, fill_done, drop;
  logic [ADDR_W:0]   waddr;
  logic              load, bank_release, rd_bank;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W:0]   rd_addr;

  // Natural or bit-reversed read order; the counter itself always runs 0..SYMBOL_LEN-1.
  function automatic logic [ADDR_W-1:0] bit_map(input logic [ADDR_W-1:0] idx);
`ifdef BIT_REVERSE_EN
    for (int i = 0; i < ADDR_W; i++) bit_map[i] = idx[ADDR_W-1-i];
`else
    bit_map = idx;
`endif
  endfunction

  // Input stalls only when both banks hold unread symbols.
  assign asi_in0.ready = ~(full[0] & full[1]);
  assign in_xfer       = asi_in0.valid & asi_in0.ready;
  assign sample        = asi_in0.data[DATA_W:1];
  assign in_sop        = asi_in0.startofpacket;
  assign in_eop        = asi_in0.endofpacket;

  // Data is gated by valid so a reset or idle output reads as zero even though ram_q is unreset.
  assign aso_out0.data          = out_valid ? ram_q : '0;
  assign aso_out0.valid         = out_valid;
  assign aso_out0.startofpacket = out_sop;
  assign aso_out0.endofpacket   = out_eop;

  // Write-side decode: what the current input beat does to the write bank.
  always_comb begin
    we        = 1'b0;
    start     = 1'b0;
    fill_done = 1'b0;
    drop      = 1'b0;
    waddr     = {wbank, wcnt};
    if (in_xfer) begin
      case (wstate)
        W_IDLE, W_DISCARD: begin
          if (in_sop) begin
            we    = 1'b1;
            start = 1'b1;
            waddr = {wbank, {ADDR_W{1'b0}}};
          end
        end
        W_FILL: begin
          if (in_sop) begin
            we    = 1'b1;
            start = 1'b1;
            drop  = 1'b1;
            waddr = {wbank, {ADDR_W{1'b0}}};
          end else if (wcnt == LAST) begin
            we        = 1'b1;
            fill_done = 1'b1;
          end else if (in_eop) begin
            drop = 1'b1;
          end else begin
            we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write FSM: symbol framing, write bank selection and the saturating drop counter.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wstate     <= W_IDLE;
      wcnt       <= '0;
      wbank      <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (start) begin
        wcnt   <= ADDR_W'(1);
        wstate <= W_FILL;
      end else if (fill_done) begin
        wcnt   <= '0;
        wbank  <= ~wbank;
        wstate <= in_eop ? W_IDLE : W_DISCARD;
      end else if (in_xfer && wstate == W_FILL) begin
        if (in_eop) begin
          wcnt   <= '0;
          wstate <= W_IDLE;
        end else begin
          wcnt <= wcnt + ADDR_W'(1);
        end
      end else if (in_xfer && wstate == W_DISCARD && in_eop) begin
        wstate <= W_IDLE;
      end
    end
  end

  // Read-side decode: which word to fetch next and when the current bank is handed back.
  always_comb begin
    load         = 1'b0;
    bank_release = 1'b0;
    rd_bank      = rbank;
    rd_idx       = rcnt + ADDR_W'(1);
    case (rstate)
      R_FETCH: begin
        load   = 1'b1;
        rd_idx = '0;
      end
      R_STREAM: begin
        if (aso_out0.ready) begin
          if (rcnt == LAST) begin
            bank_release = 1'b1;
            rd_bank      = !rbank;
            rd_idx       = '0;
            load         = full[!rbank];
          end else begin
            load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rd_addr = {rd_bank, bit_map(rd_idx)};

  // Read FSM: replay one bank per packet, prefetching the other bank's first word on eop.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rstate    <= R_IDLE;
      rcnt      <= '0;
      rbank     <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (full[rbank]) rstate <= R_FETCH;
        end
        R_FETCH: begin
          out_valid <= 1'b1;
          out_sop   <= 1'b1;
          out_eop   <= 1'b0;
          rcnt      <= '0;
          rstate    <= R_STREAM;
        end
        R_STREAM: begin
          if (aso_out0.ready) begin
            if (rcnt == LAST) begin
              rbank <= ~rbank;
              rcnt  <= '0;
              if (full[!rbank]) begin
                out_sop <= 1'b1;
                out_eop <= 1'b0;
              end else begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
                rstate    <= R_IDLE;
              end
            end else begin
              rcnt    <= rcnt + ADDR_W'(1);
              out_sop <= 1'b0;
              out_eop <= (rcnt + ADDR_W'(1)) == LAST;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Bank full flags: set by a completed fill, cleared by the eop transfer of that bank.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      full <= '0;
    end else begin
      if (fill_done)    full[wbank] <= 1'b1;
      if (bank_release) full[rbank] <= 1'b0;
    end
  end

  // Sample storage with a registered read port feeding the output.
  always_ff @(posedge clock_clk) begin
    if (we)   mem[waddr] <= sample;
    if (load) ram_q      <= mem[rd_addr];
  end

endmodule

// File: tb/tb_ofdm_symbol_buffer.sv
// tb/tb_ofdm_symbol_buffer.sv - directed self-checking bench for ofdm_symbol_buffer
module tb_ofdm_symbol_buffer;
  localparam int LEN = 64;
  localparam int AW  = 6;
  localparam int DW  = 32;

  logic        clock_clk   = 1'b0;
  logic        reset_reset = 1'b1;
  logic [15:0] drop_count;

  ofdm_symbol_buffer_if #(.W(DW+1)) asi_in0 ();
  ofdm_symbol_buffer_if #(.W(DW))   aso_out0 ();

  ofdm_symbol_buffer #(.SYMBOL_LEN(LEN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .asi_in0     (asi_in0),
    .aso_out0    (aso_out0),
    .drop_count  (drop_count)
  );

  always #5 clock_clk = ~clock_clk;

  int cyc = 0;
  always @(posedge clock_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] q_data[$];
  logic          q_sop[$];
  logic          q_eop[$];
  int            q_cyc[$];
  int            exp_q[$];
  int            first_valid_cyc = -1;
  int            last_in_cyc = 0;
  logic          p_stall = 1'b0;
  logic [DW-1:0] p_data;
  logic          p_sop, p_eop;

  // Output monitor: collects accepted beats and checks hold-stable behaviour on stalls.
  always @(negedge clock_clk) begin
    if (reset_reset) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("hold_data", 64'(aso_out0.data), 64'(p_data));
        check("hold_ctl", 64'({aso_out0.valid, aso_out0.startofpacket, aso_out0.endofpacket}),
              64'({1'b1, p_sop, p_eop}));
      end
      if (aso_out0.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (aso_out0.valid && aso_out0.ready) begin
        q_data.push_back(aso_out0.data);
        q_sop.push_back(aso_out0.startofpacket);
        q_eop.push_back(aso_out0.endofpacket);
        q_cyc.push_back(cyc);
      end
      p_stall = aso_out0.valid & ~aso_out0.ready;
      p_data  = aso_out0.data;
      p_sop   = aso_out0.startofpacket;
      p_eop   = aso_out0.endofpacket;
    end
  end

  task automatic step();
    @(posedge clock_clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete(); exp_q.delete();
    first_valid_cyc = -1;
  endtask

  // One input beat; returns at posedge+1 after the beat was accepted.
  task automatic send(input int v, input logic s, input logic e);
    int   n;
    logic ok;
    n = 0;
    asi_in0.data          = {DW'(v), 1'($urandom)};
    asi_in0.valid         = 1'b1;
    asi_in0.startofpacket = s;
    asi_in0.endofpacket   = e;
    do begin
      @(negedge clock_clk);
      ok = asi_in0.ready;
      @(posedge clock_clk);
      n++;
    end while (!ok && n < 3000);
    if (!ok) check("in_ready_timeout", 64'(0), 64'(1));
    #1;
    last_in_cyc           = cyc;
    asi_in0.valid         = 1'b0;
    asi_in0.startofpacket = 1'b0;
    asi_in0.endofpacket   = 1'b0;
  endtask

  task automatic send_sym(input int base, input int n, input logic sopf, input logic eopl);
    for (int i = 0; i < n; i++) send(base + i, (i == 0) && sopf, (i == n - 1) && eopl);
  endtask

  task automatic expect_sym(input int base);
    for (int i = 0; i < LEN; i++) exp_q.push_back(base + i);
  endtask

  // Waits (bounded) for all expected beats, lets the output settle, then compares in order.
  task automatic compare_all(input string tag);
    int t;
    t = 0;
    while (q_data.size() < exp_q.size() && t < 4000) begin
      step();
      t++;
    end
    repeat (6) step();
    check({tag, "_count"}, 64'(q_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q_data.size(); i++) begin
      check({tag, "_data"}, 64'(q_data[i]), 64'(exp_q[i]));
      check({tag, "_sop"}, 64'(q_sop[i]), 64'((i % LEN) == 0));
      check({tag, "_eop"}, 64'(q_eop[i]), 64'((i % LEN) == LEN - 1));
    end
  endtask

  function automatic int rev_idx(input int x);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) if (x[i]) r = r | (1 << (AW - 1 - i));
    return r;
  endfunction

  initial begin
    int t;
    asi_in0.data          = '0;
    asi_in0.valid         = 1'b0;
    asi_in0.startofpacket = 1'b0;
    asi_in0.endofpacket   = 1'b0;
    aso_out0.ready        = 1'b1;
    repeat (3) step();
    reset_reset = 1'b0;
    step();

    // Reset state
    check("rst_out", 64'({aso_out0.valid, aso_out0.startofpacket, aso_out0.endofpacket}), 64'(0));
    check("rst_data", 64'(aso_out0.data), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));

    // 1: single symbol, ready held high, latency 2 after the last sample
    clear_q();
    send_sym(1, LEN, 1'b1, 1'b1);
    expect_sym(1);
    compare_all("t1");
    check("t1_latency", 64'(first_valid_cyc - last_in_cyc), 64'(2));

    // 2: stray samples, short packet, mid-symbol sop, overlong symbol
    clear_q();
    send_sym(900, 3, 1'b0, 1'b0);
    send_sym(10, 10, 1'b1, 1'b1);
    repeat (10) step();
    check("t2_no_out", 64'(q_data.size()), 64'(0));
    check("t2_drop1", 64'(drop_count), 64'(1));
    send_sym(101, LEN, 1'b1, 1'b1);
    expect_sym(101);
    compare_all("t2a");
    clear_q();
    send_sym(20, 5, 1'b1, 1'b0);
    send_sym(201, LEN, 1'b1, 1'b1);
    expect_sym(201);
    compare_all("t2b");
    check("t2_drop2", 64'(drop_count), 64'(2));
    clear_q();
    send_sym(301, LEN, 1'b1, 1'b0);
    send_sym(950, 3, 1'b0, 1'b1);
    send_sym(401, LEN, 1'b1, 1'b1);
    expect_sym(301);
    expect_sym(401);
    compare_all("t2c");
    check("t2_drop_keep", 64'(drop_count), 64'(2));

    // 3: sink stalled, three symbols, input stalls after the second
    clear_q();
    aso_out0.ready = 1'b0;
    send_sym(200, LEN, 1'b1, 1'b1);
    check("t3_ready_one", 64'(asi_in0.ready), 64'(1));
    send_sym(300, LEN, 1'b1, 1'b1);
    check("t3_ready_zero", 64'(asi_in0.ready), 64'(0));
    fork
      send_sym(400, LEN, 1'b1, 1'b1);
      begin
        repeat (5) step();
        aso_out0.ready = 1'b1;
      end
    join
    expect_sym(200);
    expect_sym(300);
    expect_sym(400);
    compare_all("t3");
    if (q_cyc.size() > LEN) check("t3_no_bubble", 64'(q_cyc[LEN] - q_cyc[LEN-1]), 64'(1));
    else check("t3_no_bubble", 64'(q_cyc.size()), 64'(LEN + 1));

    // 4: sink ready toggling every cycle
    clear_q();
    fork
      send_sym(500, LEN, 1'b1, 1'b1);
      begin
        t = 0;
        while (q_data.size() < LEN && t < 600) begin
          step();
          aso_out0.ready = ~aso_out0.ready;
          t++;
        end
        aso_out0.ready = 1'b1;
      end
    join
    expect_sym(500);
    compare_all("t4");

    // 5: reset in the middle of a replay
    clear_q();
    aso_out0.ready = 1'b1;
    send_sym(600, LEN, 1'b1, 1'b1);
    t = 0;
    while (q_data.size() < 30 && t < 500) begin
      step();
      t++;
    end
    check("t5_reached30", 64'(q_data.size() >= 30), 64'(1));
    reset_reset = 1'b1;
    #1;
    check("t5_rst_ctl", 64'({aso_out0.valid, aso_out0.startofpacket, aso_out0.endofpacket}), 64'(0));
    check("t5_rst_data", 64'(aso_out0.data), 64'(0));
    check("t5_rst_drop", 64'(drop_count), 64'(0));
    step();
    step();
    reset_reset = 1'b0;
    step();
    clear_q();
    send_sym(700, LEN, 1'b1, 1'b1);
    expect_sym(700);
    compare_all("t5");

    // 6: sample i = i; bit-reversed order when the feature is built in
    clear_q();
    send_sym(0, LEN, 1'b1, 1'b1);
    for (int i = 0; i < LEN; i++) begin
`ifdef BIT_REVERSE_EN
      exp_q.push_back(rev_idx(i));
`else
      exp_q.push_back(i);
`endif
    end
    compare_all("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
